// File: rtl/fetchflare_engine_dispatcher.sv
// Dispatches prefetch descriptors to NUM_ENGINES stride engines over a shared config bus.
// Optional round-robin engine selection is enabled by defining FETCHFLARE_DISPATCH_RR_EN.
module fetchflare_engine_dispatcher #(
  parameter int NUM_ENGINES = 4,
  parameter int ENG_IDX_W   = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   entry_valid_i,
  output logic                   entry_ready_o,
  input  logic [159:0]           entry_i,
  input  logic                   flush_i,
  input  logic [NUM_ENGINES-1:0] engine_done_i,
  output logic                   cfg_we_o,
  output logic [ENG_IDX_W-1:0]   cfg_engine_o,
  output logic [1:0]             cfg_reg_o,
  output logic [63:0]            cfg_wdata_o,
  output logic [NUM_ENGINES-1:0] busy_o,
  output logic                   idle_o,
  output logic [15:0]            dispatch_count_o
);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WR_PARAM    = 2'd1,
    ST_WR_THROTTLE = 2'd2,
    ST_WR_BASE     = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [63:0]            base_q, base_d;
  logic [63:0]            param_q, param_d;
  logic [31:0]            thr_q, thr_d;
  logic [ENG_IDX_W-1:0]   sel_q, sel_d;
  logic [ENG_IDX_W-1:0]   pick;
  logic [NUM_ENGINES-1:0] busy_q, busy_d;
  logic [NUM_ENGINES-1:0] free;
  logic [15:0]            cnt_q, cnt_d;
  logic                   entry_en;
  logic                   accept;

  assign free     = ~busy_q;
  assign entry_en = entry_i[96];

`ifdef FETCHFLARE_DISPATCH_RR_EN
  logic [ENG_IDX_W-1:0] rr_q, rr_d;
  int                   dist;
  int                   best;

  // Pick the free engine with the smallest circular distance from the pointer.
  always_comb begin
    pick = '0;
    dist = 0;
    best = NUM_ENGINES;
    for (int j = 0; j < NUM_ENGINES; j++) begin
      dist = (j >= int'(rr_q)) ? (j - int'(rr_q)) : (j + NUM_ENGINES - int'(rr_q));
      if (free[j] && (dist < best)) begin
        best = dist;
        pick = ENG_IDX_W'(j);
      end
    end
  end
`else
  always_comb begin
    pick = '0;
    for (int j = NUM_ENGINES - 1; j >= 0; j--) begin
      if (free[j]) begin
        pick = ENG_IDX_W'(j);
      end
    end
  end
`endif

  assign entry_ready_o = (state_q == ST_IDLE) && !flush_i && !rst_i && ((|free) || !entry_en);
  assign accept        = entry_valid_i && entry_ready_o;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    param_d = param_q;
    thr_d   = thr_q;
    sel_d   = sel_q;
    busy_d  = busy_q & ~engine_done_i;
    cnt_d   = cnt_q;
`ifdef FETCHFLARE_DISPATCH_RR_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept && entry_en) begin
          base_d  = entry_i[159:96];
          param_d = entry_i[95:32];
          thr_d   = entry_i[31:0];
          sel_d   = pick;
          state_d = ST_WR_PARAM;
        end
      end
      ST_WR_PARAM:    state_d = ST_WR_THROTTLE;
      ST_WR_THROTTLE: state_d = ST_WR_BASE;
      ST_WR_BASE: begin
        // The engine is armed by this write, so it becomes busy even if a stray done arrives now.
        busy_d[sel_q] = 1'b1;
        cnt_d         = cnt_q + 16'd1;
`ifdef FETCHFLARE_DISPATCH_RR_EN
        rr_d          = (int'(sel_q) + 1 == NUM_ENGINES) ? '0 : sel_q + 1'b1;
`endif
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) begin
      state_d = ST_IDLE;
      busy_d  = '0;
      cnt_d   = cnt_q;
`ifdef FETCHFLARE_DISPATCH_RR_EN
      rr_d    = '0;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      param_q <= '0;
      thr_q   <= '0;
      sel_q   <= '0;
      busy_q  <= '0;
      cnt_q   <= '0;
`ifdef FETCHFLARE_DISPATCH_RR_EN
      rr_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      param_q <= param_d;
      thr_q   <= thr_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
`ifdef FETCHFLARE_DISPATCH_RR_EN
      rr_q    <= rr_d;
`endif
    end
  end

  always_comb begin
    cfg_reg_o   = 2'd0;
    cfg_wdata_o = '0;
    case (state_q)
      ST_WR_PARAM: begin
        cfg_reg_o   = 2'd1;
        cfg_wdata_o = param_q;
      end
      ST_WR_THROTTLE: begin
        cfg_reg_o   = 2'd2;
        cfg_wdata_o = {32'b0, thr_q};
      end
      ST_WR_BASE: begin
        cfg_reg_o   = 2'd0;
        cfg_wdata_o = base_q;
      end
      default: begin
        cfg_reg_o   = 2'd0;
        cfg_wdata_o = '0;
      end
    endcase
  end

  assign cfg_we_o         = (state_q != ST_IDLE) && !flush_i && !rst_i;
  assign cfg_engine_o     = (state_q == ST_IDLE) ? '0 : sel_q;
  assign busy_o           = busy_q;
  assign idle_o           = (state_q == ST_IDLE) && (busy_q == '0);
  assign dispatch_count_o = cnt_q;

endmodule

// File: doc/fetchflare_engine_dispatcher.md
Name: fetchflare_engine_dispatcher

Overview:
- Scheduler between the prefetch-request queue (descriptor queue) and a bank of NUM_ENGINES stride prefetch engines.
- Pops one descriptor at a time, holding base, param and throttle words, and picks a free engine.
- Programs that engine over a shared single-beat config write bus: param, then throttle, then base last, so the enable bit arms the engine atomically.
- Tracks per-engine busy state until each engine reports completion.

Parameters:
- NUM_ENGINES, 4, number of prefetch engines; legal range 1..16.
- ENG_IDX_W, $clog2(NUM_ENGINES) with a minimum of 1, engine index width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- entry_valid_i  in  1  descriptor valid.
- entry_ready_o  out  1  descriptor accepted when valid&&ready.
- entry_i  in  160  descriptor {base[159:96], param[95:32], throttle[31:0]}. base bit 96 is the enable bit.
- flush_i  in  1  abort sequence and clear all busy state.
- engine_done_i  in  NUM_ENGINES  one-cycle pulse per engine when its stream finishes.
- cfg_we_o  out  1  config write strobe.
- cfg_engine_o  out  ENG_IDX_W  target engine.
- cfg_reg_o  out  2  register select: 0=base, 1=param, 2=throttle.
- cfg_wdata_o  out  64  write data.
- busy_o  out  NUM_ENGINES  registered busy mask.
- idle_o  out  1  FSM in IDLE and busy_o==0.
- dispatch_count_o  out  16  number of engines armed; wraps.

Behaviour:
- Reset:
  - Outputs: cfg_we_o=0, cfg_engine_o=0, cfg_reg_o=0, cfg_wdata_o=0, busy_o=0, dispatch_count_o=0, entry_ready_o=0 during the reset cycle, idle_o=1 from the first cycle after reset.
  - State: FSM=IDLE, RR pointer=0.
- FSM states: IDLE, WR_PARAM, WR_THROTTLE, WR_BASE.
- IDLE:
  - entry_ready_o = !flush_i && (any ~busy_o bit set || entry_i.base.enable==0).
  - entry_ready_o may depend combinationally on entry_i and entry_valid_i.
  - On handshake with enable==0: descriptor is dropped; no writes; stay in IDLE.
  - On handshake with enable==1: latch descriptor and selected engine index; go to WR_PARAM.
- WR_PARAM: cfg_we_o=1, cfg_reg_o=1, cfg_wdata_o=param; go to WR_THROTTLE.
- WR_THROTTLE: cfg_we_o=1, cfg_reg_o=2, cfg_wdata_o={32'b0,throttle}; go to WR_BASE.
- WR_BASE: cfg_we_o=1, cfg_reg_o=0, cfg_wdata_o=base.
  - busy_o[sel] is set at the end of the cycle.
  - dispatch_count_o increments.
  - Go to IDLE.
- cfg_engine_o holds the selected index throughout the three write states.
- cfg_we_o=0 in IDLE.
- All cfg outputs are registered state decodes; the write bus has no backpressure.
- Latency: handshake in cycle T → writes in T+1..T+3 → busy visible at T+4 → next handshake possible at T+4. Peak rate is one dispatch per 4 cycles.
- Engine selection:
  - Made in IDLE from the registered busy_o, so a done pulse makes its engine selectable only in the following cycle.
  - Base selection is lowest free index (see Optional Feature for round-robin).
- engine_done_i[k]:
  - Clears busy_o[k] at the next clock edge.
  - Ignored if busy_o[k]==0, including the engine currently being programmed.
  - A done for engine j and a WR_BASE set for engine k≠j in the same cycle both take effect.
- flush_i:
  - Highest priority over all other behaviour.
  - In the flush cycle: cfg_we_o is forced 0 combinationally and entry_ready_o=0.
  - At the next clock edge: FSM=IDLE, busy_o=0, RR pointer=0.
  - dispatch_count_o is retained.
  - A sequence aborted before WR_BASE leaves the engine unarmed, because base is always written last.
- rst_i mid-sequence: same outcome as flush, and additionally dispatch_count_o=0.

Optional Feature:
- Macro: FETCHFLARE_DISPATCH_RR_EN.
- Defined:
  - Selection is round-robin: first free engine at index ≥ RR pointer, wrapping modulo NUM_ENGINES.
  - On each WR_BASE, the RR pointer becomes (sel+1) mod NUM_ENGINES.
- Undefined:
  - Fixed priority: lowest free index.
  - No RR pointer register.

Test Plan:
- Basic dispatch: reset, then one descriptor with base=64'h0000_0000_8000_0041, param=64'h0004_0010_0000_0040, throttle=32'h0002_0008. Required: writes to engine 0 at T+1/T+2/T+3 with reg 1/2/0 and data param / 64'h0000_0000_0002_0008 / base; busy_o=4'b0001 at T+4; dispatch_count_o=1.
- Fill and backpressure: 5 back-to-back enabled descriptors with NUM_ENGINES=4 → engines 0,1,2,3 armed at 4-cycle spacing; busy_o=4'hF; entry_ready_o=0 for the 5th. Pulse engine_done_i=4'b0100 → 5th descriptor is accepted next cycle and targets engine 2.
- Drop: descriptor with base bit 0 = 0 while busy_o=4'hF → accepted in 1 cycle; no cfg_we_o; dispatch_count_o unchanged.
- Flush mid-sequence: assert flush_i during the WR_THROTTLE cycle → cfg_we_o=0 that cycle; no base write occurs; next cycle idle_o=1 and busy_o=0.
- Done edge cases: engine_done_i[1] while busy_o[1]=0 → no change. Simultaneous done[0] and WR_BASE to engine 1 with busy_o=4'b0001 → busy_o=4'b0010.
- RR (FETCHFLARE_DISPATCH_RR_EN): arm engines 0,1; pulse done[0]; next dispatch goes to engine 2, not 0. Without the macro it goes to engine 0.
